// File: rtl/adma_atx_split.sv
// adma_atx_split: splits one DMA TX descriptor into AXI address transactions (ATXs).
// Define ADMA_ATX_4K_BOUNDARY_EN to keep every ATX inside a single 4 KB page.
module adma_atx_split #(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DMA_LENGTH_W  = 16,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned MAX_BURST_LEN = 16,
   parameter int unsigned ATX_NUM_OSTD  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tx_vld_i,
   output logic                    tx_rdy_o,
   input  logic [ADDR_W-1:0]       tx_addr_i,
   input  logic [DMA_LENGTH_W-1:0] tx_len_i,
   output logic                    atx_vld_o,
   input  logic                    atx_rdy_i,
   output logic [ADDR_W-1:0]       atx_addr_o,
   output logic [7:0]              atx_len_o,
   output logic                    atx_last_o,
   output logic                    atx_start_o,
   output logic                    atx_start_last_o,
   input  logic                    atx_done_i,
   output logic                    idle_o
);

   localparam int unsigned Bytes   = DATA_W / 8;
   localparam int unsigned AddrLsb = $clog2(Bytes);
   localparam int unsigned RemW    = DMA_LENGTH_W + 1;
   localparam int unsigned CalcW   = RemW + 13;
   localparam int unsigned OstdW   = $clog2(ATX_NUM_OSTD + 1);
   localparam logic [ADDR_W-1:0] AddrMask = ~(ADDR_W'(Bytes - 1));

   typedef enum logic [1:0] {StIdle, StCalc, StIssue} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [RemW-1:0]   remain_q, remain_d;
   logic [8:0]        burst_q, burst_d;
   logic              last_q, last_d;
   logic [OstdW-1:0]  ostd_q, ostd_d;

   logic [CalcW-1:0]  remain_ext;
   logic [CalcW-1:0]  burst_c;
   logic              atx_start;

   // Burst size for the ATX at cur_addr_q; only consumed in CALC.
   always_comb begin
      remain_ext = CalcW'(remain_q);
      burst_c    = (remain_ext < CalcW'(MAX_BURST_LEN)) ? remain_ext : CalcW'(MAX_BURST_LEN);
`ifdef ADMA_ATX_4K_BOUNDARY_EN
      begin
         logic [CalcW-1:0] to_4k;
         to_4k = (CalcW'(4096) - CalcW'(cur_addr_q[11:0])) >> AddrLsb;
         if (to_4k < burst_c) burst_c = to_4k;
      end
`endif
   end

   assign atx_start = atx_vld_o & atx_rdy_i;

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      remain_d   = remain_q;
      burst_d    = burst_q;
      last_d     = last_q;
      unique case (state_q)
         StIdle: begin
            if (tx_vld_i) begin
               cur_addr_d = tx_addr_i & AddrMask;
               remain_d   = RemW'(tx_len_i) + RemW'(1);
               state_d    = StCalc;
            end
         end
         StCalc: begin
            burst_d = burst_c[8:0];
            last_d  = (burst_c == remain_ext);
            state_d = StIssue;
         end
         StIssue: begin
            if (atx_start) begin
               cur_addr_d = cur_addr_q + (ADDR_W'(burst_q) << AddrLsb);
               remain_d   = remain_q - RemW'(burst_q);
               state_d    = last_q ? StIdle : StCalc;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A done pulse with nothing outstanding is dropped.
   always_comb begin
      ostd_d = ostd_q;
      if (atx_start && !(atx_done_i && ostd_q != '0)) begin
         ostd_d = ostd_q + OstdW'(1);
      end else if (!atx_start && atx_done_i && ostd_q != '0) begin
         ostd_d = ostd_q - OstdW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cur_addr_q <= '0;
         remain_q   <= '0;
         burst_q    <= 9'd1;
         last_q     <= 1'b0;
         ostd_q     <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         remain_q   <= remain_d;
         burst_q    <= burst_d;
         last_q     <= last_d;
         ostd_q     <= ostd_d;
      end
   end

   assign tx_rdy_o         = (state_q == StIdle);
   assign atx_vld_o        = (state_q == StIssue) && (ostd_q < OstdW'(ATX_NUM_OSTD));
   assign atx_addr_o       = cur_addr_q;
   assign atx_len_o        = 8'(burst_q - 9'd1);
   assign atx_last_o       = last_q;
   assign atx_start_o      = atx_start;
   assign atx_start_last_o = atx_start & last_q;
   assign idle_o           = (state_q == StIdle) && (ostd_q == '0);

endmodule

// File: tb/tb_adma_atx_split.sv
// Scoreboard bench for adma_atx_split: a page/burst-splitting model queues the expected
// ATXs per descriptor and a negedge monitor pops and compares them on every atx_start_o.
module tb_adma_atx_split;

   localparam int unsigned AddrW    = 32;
   localparam int unsigned LenW     = 16;
   localparam int unsigned DataW    = 32;
   localparam int unsigned MaxBurst = 16;
   localparam int unsigned NumOstd  = 4;
   localparam int unsigned Bytes    = DataW / 8;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic        last;
   } atx_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             tx_vld, tx_rdy_o;
   logic [AddrW-1:0] tx_addr;
   logic [LenW-1:0]  tx_len;
   logic             atx_vld_o, atx_rdy, atx_last_o, atx_start_o, atx_start_last_o;
   logic [AddrW-1:0] atx_addr_o;
   logic [7:0]       atx_len_o;
   logic             atx_done, idle_o;

   atx_t        exp_q[$];
   atx_t        e;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int unsigned n_starts = 0;
   int unsigned n_start_last = 0;
   int unsigned tb_ostd = 0;
   logic        auto_en = 1'b0;
   logic        stall_q = 1'b0;
   logic [31:0] stall_addr;
   logic [7:0]  stall_len;
   logic        stall_last;

   adma_atx_split #(
      .ADDR_W       (AddrW),
      .DMA_LENGTH_W (LenW),
      .DATA_W       (DataW),
      .MAX_BURST_LEN(MaxBurst),
      .ATX_NUM_OSTD (NumOstd)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tx_vld_i        (tx_vld),
      .tx_rdy_o        (tx_rdy_o),
      .tx_addr_i       (tx_addr),
      .tx_len_i        (tx_len),
      .atx_vld_o       (atx_vld_o),
      .atx_rdy_i       (atx_rdy),
      .atx_addr_o      (atx_addr_o),
      .atx_len_o       (atx_len_o),
      .atx_last_o      (atx_last_o),
      .atx_start_o     (atx_start_o),
      .atx_start_last_o(atx_start_last_o),
      .atx_done_i      (atx_done),
      .idle_o          (idle_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: walk the descriptor page by page / burst by burst.
   task automatic model_push(input logic [31:0] a_in, input logic [15:0] l);
      logic [31:0] a;
      int unsigned rem, b, room;
      a   = a_in & ~32'(Bytes - 1);
      rem = int'(l) + 1;
      while (rem != 0) begin
         b = (rem < MaxBurst) ? rem : MaxBurst;
`ifdef ADMA_ATX_4K_BOUNDARY_EN
         room = (4096 - (a % 4096)) / Bytes;
         if (room < b) b = room;
`else
         room = 0;
`endif
         exp_q.push_back('{a, 8'(b - 1), (b == rem)});
         a   = a + 32'(b * Bytes);
         rem = rem - b;
      end
   endtask

   task automatic send_tx(input logic [31:0] a, input logic [15:0] l);
      int unsigned t;
      t = 0;
      while (!tx_rdy_o && t < 1000) begin
         tick();
         t++;
      end
      check("tx_rdy_wait", tx_rdy_o, 1'b1);
      model_push(a, l);
      tx_vld  = 1'b1;
      tx_addr = a;
      tx_len  = l;
      tick();
      tx_vld  = 1'b0;
      tx_addr = $urandom;
      tx_len  = 16'($urandom);
      check("tx_to_atx_min_latency", atx_vld_o, 1'b0);
   endtask

   task automatic wait_drain(input int unsigned max_cycles);
      int unsigned t;
      t = 0;
      while (!(exp_q.size() == 0 && idle_o) && t < max_cycles) begin
         tick();
         t++;
      end
      check("drain_in_budget", (exp_q.size() == 0 && idle_o), 1'b1);
   endtask

   // Random AXI-side ready and completion traffic.
   always @(posedge clk) begin
      #1;
      if (auto_en) begin
         atx_rdy  = ($urandom_range(0, 3) != 0);
         atx_done = (tb_ostd > 0) && ($urandom_range(0, 1) == 0);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         tb_ostd = 0;
         stall_q = 1'b0;
         check("rst_no_start_last", atx_start_last_o, 1'b0);
      end else begin
         if (stall_q) begin
            check("hold_vld", atx_vld_o, 1'b1);
            check("hold_addr", atx_addr_o, stall_addr);
            check("hold_len", atx_len_o, stall_len);
            check("hold_last", atx_last_o, stall_last);
         end
         if (atx_start_o) begin
            n_starts++;
            check("ostd_limit", (tb_ostd < NumOstd), 1'b1);
            check("atx_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("atx_addr", atx_addr_o, e.addr);
               check("atx_len", atx_len_o, e.len);
               check("atx_last", atx_last_o, e.last);
               check("atx_start_last", atx_start_last_o, e.last);
            end
         end else if (atx_start_last_o) begin
            check("start_last_without_start", atx_start_o, 1'b1);
         end
         if (atx_start_last_o) n_start_last++;
         if (atx_start_o && !(atx_done && tb_ostd > 0)) tb_ostd++;
         else if (!atx_start_o && atx_done && tb_ostd > 0) tb_ostd--;
         stall_q    = atx_vld_o && !atx_rdy;
         stall_addr = atx_addr_o;
         stall_len  = atx_len_o;
         stall_last = atx_last_o;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d",
               n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base, t;
      logic [31:0] a, s_addr;
      logic [7:0]  s_len;
      logic        s_last;
      tx_vld = 1'b0; tx_addr = '0; tx_len = '0; atx_rdy = 1'b0; atx_done = 1'b0;

      repeat (2) tick();
      check("rst_tx_rdy", tx_rdy_o, 1'b1);
      check("rst_idle", idle_o, 1'b1);
      check("rst_vld", atx_vld_o, 1'b0);
      check("rst_start", atx_start_o, 1'b0);
      check("rst_last", atx_last_o, 1'b0);
      check("rst_addr", atx_addr_o, 32'h0);
      check("rst_len", atx_len_o, 8'h0);
      rst_n = 1'b1;
      tick();

      // Directed descriptors under random ready/done.
      auto_en = 1'b1;
      send_tx(32'h1000, 16'd15);
      wait_drain(500);
      check("single_atx_start_last_count", n_start_last, 1);
      send_tx(32'h0, 16'd39);
      wait_drain(500);
      send_tx(32'hFF8, 16'd7);
      wait_drain(500);

      // Outstanding limit with no completions.
      auto_en = 1'b0; atx_rdy = 1'b1; atx_done = 1'b0;
      base = n_starts;
      send_tx(32'h2000, 16'd95);
      repeat (20) tick();
      check("ostd_cap_starts", n_starts - base, NumOstd);
      check("ostd_cap_vld_low", atx_vld_o, 1'b0);
      atx_done = 1'b1;
      check("vld_low_during_done", atx_vld_o, 1'b0);
      tick();
      atx_done = 1'b0;
      check("vld_after_done", atx_vld_o, 1'b1);
      auto_en = 1'b1;
      wait_drain(1000);

      // Back-pressure stall and timing of the CALC bubble / TX ready.
      auto_en = 1'b0; atx_rdy = 1'b0; atx_done = 1'b0;
      send_tx(32'h3000, 16'd31);
      tick();
      check("first_atx_latency", atx_vld_o, 1'b1);
      s_addr = atx_addr_o; s_len = atx_len_o; s_last = atx_last_o;
      repeat (5) begin
         tick();
         check("stall_addr", atx_addr_o, s_addr);
         check("stall_len", atx_len_o, s_len);
         check("stall_last", atx_last_o, s_last);
      end
      atx_rdy = 1'b1;
      tick();
      atx_rdy = 1'b0;
      check("calc_bubble", atx_vld_o, 1'b0);
      check("tx_rdy_mid_tx", tx_rdy_o, 1'b0);
      tick();
      check("next_atx_after_bubble", atx_vld_o, 1'b1);
      check("advanced_addr", atx_addr_o, 32'h3040);
      atx_rdy = 1'b1;
      tick();
      atx_rdy = 1'b0;
      check("tx_rdy_after_last", tx_rdy_o, 1'b1);
      auto_en = 1'b1;
      wait_drain(500);

      // Reset in ISSUE with two ATXs outstanding.
      auto_en = 1'b0; atx_rdy = 1'b1; atx_done = 1'b0;
      send_tx(32'h4000, 16'd63);
      t = 0;
      while (tb_ostd != 2 && t < 100) begin
         tick();
         t++;
      end
      atx_rdy = 1'b0;
      check("two_outstanding", tb_ostd, 2);
      t = 0;
      while (!atx_vld_o && t < 100) begin
         tick();
         t++;
      end
      check("in_issue_before_reset", atx_vld_o, 1'b1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_vld", atx_vld_o, 1'b0);
      check("mid_rst_tx_rdy", tx_rdy_o, 1'b1);
      check("mid_rst_addr", atx_addr_o, 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_tx_rdy", tx_rdy_o, 1'b1);
      check("post_rst_idle", idle_o, 1'b1);
      check("post_rst_vld", atx_vld_o, 1'b0);
      auto_en = 1'b1;
      send_tx(32'h5004, 16'd20);
      wait_drain(500);

      // Random descriptors, some near page ends, plus address wrap and maximum length.
      for (int i = 0; i < 25; i++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[11:0] = 12'($urandom_range(12'hF00, 12'hFFF));
         send_tx(a, 16'($urandom_range(0, 100)));
         wait_drain(2000);
      end
      send_tx(32'hFFFF_FFE0, 16'd20);
      wait_drain(500);
      send_tx(32'h0000_0100, 16'hFFFF);
      wait_drain(60000);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
